multicycle_ctrl: RTL and testbench

//  Multicycle control FSM for the Stage-2 register/IR datapath. Decodes op/fn from the
//  IR, sequences fetch/decode/execute/memory/writeback and drives the 22-bit control

---
 rtl/coa_ctrl_pkg.sv | 82 ++++++++
 rtl/ctrl_word_rom.sv | 88 ++++++++
 rtl/multicycle_ctrl.sv | 108 ++++++++++
 tb/tb_multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/coa_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | coa_ctrl_pkg : control-word bit map, field codes, states and opcodes        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package coa_ctrl_pkg;

  // Control-word bit indices (multi-bit fields give their LSB)
  localparam int B_ALUSRCX  = 0;
  localparam int B_ALUSRCY  = 1;
  localparam int B_ALUFUNC  = 3;
  localparam int B_PCSRC    = 5;
  localparam int B_IORD     = 7;
  localparam int B_DREGSEL0 = 8;
  localparam int B_DREGSEL1 = 9;
  localparam int B_REGINSRC = 10;
  localparam int B_REGDST   = 11;
  localparam int B_REGWRITE = 13;
  localparam int B_IRWRITE  = 14;
  localparam int B_MEMREAD  = 15;
  localparam int B_MEMWRITE = 16;
  localparam int B_PCWRITE  = 17;
  localparam int B_BREQ     = 18;
  localparam int B_BRNE     = 19;

  localparam logic [1:0] Y_RT     = 2'b00;
  localparam logic [1:0] Y_FOUR   = 2'b01;
  localparam logic [1:0] Y_IMM    = 2'b10;
  localparam logic [1:0] Y_IMM_SH = 2'b11;

  localparam logic [1:0] F_ADD   = 2'b00;
  localparam logic [1:0] F_SUB   = 2'b01;
  localparam logic [1:0] F_OPFN  = 2'b10;
  localparam logic [1:0] F_PASSX = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JTA    = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_R_WB   = 4'd4,
    S_ADDR   = 4'd5,
    S_LD_MEM = 4'd6,
    S_LD_WB  = 4'd7,
    S_ST_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JAL    = 4'd11,
    S_JR     = 4'd12,
    S_I_EXEC = 4'd13,
    S_I_WB   = 4'd14,
    S_HALT   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_JR      = 6'd8;
  localparam logic [5:0] FN_SYSCALL = 6'd12;

endpackage
`default_nettype wire

// File: rtl/ctrl_word_rom.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ctrl_word_rom : state (+op, mem_ready) to control word, purely combinational |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module ctrl_word_rom
  import coa_ctrl_pkg::*;
#(
  parameter int CTRL_W = 22
) (
  input  state_e              state_i,
  input  logic [5:0]          op_i,
  input  logic                mem_ready_i,
  output logic [CTRL_W-1:0]   ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o[B_MEMREAD]        = 1'b1;
        ctrl_o[B_ALUSRCY +: 2]   = Y_FOUR;
        // IR and PC only load once the fetched word is actually valid
        ctrl_o[B_IRWRITE]        = mem_ready_i;
        ctrl_o[B_PCWRITE]        = mem_ready_i;
      end
      S_DECODE: ctrl_o[B_ALUSRCY +: 2] = Y_IMM_SH;
      S_EXEC_R: begin
        ctrl_o[B_ALUSRCX]        = 1'b1;
        ctrl_o[B_ALUFUNC +: 2]   = F_OPFN;
      end
      S_R_WB: begin
        ctrl_o[B_REGWRITE]       = 1'b1;
        ctrl_o[B_REGINSRC]       = 1'b1;
        ctrl_o[B_REGDST +: 2]    = RD_RD;
      end
      S_ADDR: begin
        ctrl_o[B_ALUSRCX]        = 1'b1;
        ctrl_o[B_ALUSRCY +: 2]   = Y_IMM;
      end
      S_LD_MEM: begin
        ctrl_o[B_MEMREAD]        = 1'b1;
        ctrl_o[B_IORD]           = 1'b1;
      end
      S_LD_WB: ctrl_o[B_REGWRITE] = 1'b1;
      S_ST_MEM: begin
        ctrl_o[B_MEMWRITE]       = 1'b1;
        ctrl_o[B_IORD]           = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o[B_ALUSRCX]        = 1'b1;
        ctrl_o[B_ALUFUNC +: 2]   = F_SUB;
        ctrl_o[B_PCSRC +: 2]     = PC_ALUOUT;
        ctrl_o[B_BREQ]           = (op_i == OP_BEQ);
        ctrl_o[B_BRNE]           = (op_i == OP_BNE);
      end
      S_JUMP: begin
        ctrl_o[B_PCSRC +: 2]     = PC_JTA;
        ctrl_o[B_PCWRITE]        = 1'b1;
      end
      S_JR: begin
        ctrl_o[B_PCSRC +: 2]     = PC_RS;
        ctrl_o[B_PCWRITE]        = 1'b1;
      end
      S_JAL: begin
        ctrl_o[B_PCSRC +: 2]     = PC_JTA;
        ctrl_o[B_PCWRITE]        = 1'b1;
        ctrl_o[B_REGWRITE]       = 1'b1;
        ctrl_o[B_REGDST +: 2]    = RD_RA;
        ctrl_o[B_REGINSRC]       = 1'b1;
        ctrl_o[B_ALUFUNC +: 2]   = F_PASSX;
      end
      S_I_EXEC: begin
        ctrl_o[B_ALUSRCX]        = 1'b1;
        ctrl_o[B_ALUSRCY +: 2]   = Y_IMM;
        ctrl_o[B_ALUFUNC +: 2]   = F_OPFN;
      end
      S_I_WB: begin
        ctrl_o[B_REGWRITE]       = 1'b1;
        ctrl_o[B_REGINSRC]       = 1'b1;
        ctrl_o[B_REGDST +: 2]    = RD_RT;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | multicycle_ctrl : multicycle control FSM with memory stall and retire count |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module multicycle_ctrl
  import coa_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 22,
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op_in,
  input  logic [5:0]         fn_in,
  input  logic               mem_ready,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic [STATE_W-1:0] state_out,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cnt_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    cnt_inc   = 1'b0;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_in)
          OP_RTYPE: begin
            if (fn_in == FN_JR) begin
              state_d = S_JR;
            end else if (fn_in == FN_SYSCALL) begin
              state_d = S_HALT;
              cnt_inc = 1'b1;
            end else begin
              state_d = S_EXEC_R;
            end
          end
          OP_J:                 state_d = S_JUMP;
          OP_JAL:               state_d = S_JAL;
          OP_BEQ, OP_BNE:       state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI: state_d = S_I_EXEC;
          OP_LW, OP_SW:         state_d = S_ADDR;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_ADDR:   state_d = (op_in == OP_LW) ? S_LD_MEM : S_ST_MEM;
      S_LD_MEM: state_d = mem_ready ? S_LD_WB : S_LD_MEM;
      S_ST_MEM: state_d = mem_ready ? S_FETCH : S_ST_MEM;
      S_R_WB, S_I_WB, S_LD_WB, S_BRANCH,
      S_JUMP, S_JR, S_JAL: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    // A retire is the return to FETCH; the first fetch after IDLE retires nothing
    if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE) begin
      cnt_inc = 1'b1;
    end
  end

  assign halted_d = halted_q | (state_d == S_HALT);
  assign count_d  = count_q + CNT_W'(cnt_inc);

  ctrl_word_rom #(.CTRL_W(CTRL_W)) u_rom (
    .state_i     (state_q),
    .op_i        (op_in),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_out)
  );

  assign state_out   = STATE_W'(state_q);
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_multicycle_ctrl : directed + random instruction streams vs. a path model |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_multicycle_ctrl;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC_R = 3, ST_R_WB = 4,
                 ST_ADDR = 5, ST_LD_MEM = 6, ST_LD_WB = 7, ST_ST_MEM = 8, ST_BRANCH = 9,
                 ST_JUMP = 10, ST_JAL = 11, ST_JR = 12, ST_I_EXEC = 13, ST_I_WB = 14,
                 ST_HALT = 15;
  localparam int CL_R = 0, CL_I = 1, CL_LW = 2, CL_SW = 3, CL_BR = 4, CL_J = 5,
                 CL_JAL = 6, CL_JR = 7, CL_SYS = 8, CL_ILL = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op_in, fn_in;
  logic        mem_ready;
  logic [21:0] ctrl_out;
  logic [3:0]  state_out;
  logic        halted, illegal;
  logic [31:0] instr_count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_cnt = 0;
  logic [5:0]  legal_ops [13] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10,
                                  6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};

  always #5 clk = ~clk;

  multicycle_ctrl #(.CTRL_W(22), .STATE_W(4), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_in       (op_in),
    .fn_in       (fn_in),
    .mem_ready   (mem_ready),
    .ctrl_out    (ctrl_out),
    .state_out   (state_out),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'd0:   return (fn == 6'd8) ? CL_JR : (fn == 6'd12) ? CL_SYS : CL_R;
      6'd2:   return CL_J;
      6'd3:   return CL_JAL;
      6'd4, 6'd5: return CL_BR;
      6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd15: return CL_I;
      6'd35:  return CL_LW;
      6'd43:  return CL_SW;
      default: return CL_ILL;
    endcase
  endfunction

  // Expected control word assembled field-by-field from the documented per-state actions
  function automatic logic [21:0] exp_ctrl(input int st, input logic [5:0] op, input logic mr);
    int x = 0, y = 0, f = 0, pc = 0, iord = 0, rin = 0, rdst = 0;
    int rw = 0, irw = 0, mrd = 0, mwr = 0, pcw = 0, beq = 0, bne = 0;
    case (st)
      ST_FETCH:  begin mrd = 1; y = 1; irw = int'(mr); pcw = int'(mr); end
      ST_DECODE: y = 3;
      ST_EXEC_R: begin x = 1; f = 2; end
      ST_R_WB:   begin rw = 1; rin = 1; rdst = 1; end
      ST_I_EXEC: begin x = 1; y = 2; f = 2; end
      ST_I_WB:   begin rw = 1; rin = 1; end
      ST_ADDR:   begin x = 1; y = 2; end
      ST_LD_MEM: begin mrd = 1; iord = 1; end
      ST_LD_WB:  rw = 1;
      ST_ST_MEM: begin mwr = 1; iord = 1; end
      ST_BRANCH: begin x = 1; f = 1; pc = 1; beq = int'(op == 6'd4); bne = int'(op == 6'd5); end
      ST_JUMP:   begin pc = 2; pcw = 1; end
      ST_JR:     begin pc = 3; pcw = 1; end
      ST_JAL:    begin pc = 2; pcw = 1; rw = 1; rdst = 2; rin = 1; f = 3; end
      default:   ;
    endcase
    return 22'(x | (y << 1) | (f << 3) | (pc << 5) | (iord << 7) | (rin << 10) | (rdst << 11)
               | (rw << 13) | (irw << 14) | (mrd << 15) | (mwr << 16) | (pcw << 17)
               | (beq << 18) | (bne << 19));
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, ".state"},   32'(state_out), ST_IDLE);
    check({tag, ".ctrl"},    32'(ctrl_out), 32'd0);
    check({tag, ".count"},   instr_count, 32'd0);
    check({tag, ".halted"},  32'(halted), 32'd0);
    check({tag, ".illegal"}, 32'(illegal), 32'd0);
  endtask

  // Async reset mid-cycle, checked immediately, then released on a falling edge
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_cleared("rst_async");
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1 check_cleared("rst_idle");
    model_cnt = 0;
  endtask

  // Runs one instruction from FETCH; fw/mw are not-ready cycles in FETCH / memory state
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input int abort_at);
    int seq[$];
    bit mrq[$];
    int cl = classify(op, fn);
    for (int i = 0; i < fw; i++) begin seq.push_back(ST_FETCH); mrq.push_back(1'b0); end
    seq.push_back(ST_FETCH);  mrq.push_back(1'b1);
    seq.push_back(ST_DECODE); mrq.push_back(1'($urandom % 2));
    case (cl)
      CL_R:   begin seq.push_back(ST_EXEC_R); seq.push_back(ST_R_WB); end
      CL_I:   begin seq.push_back(ST_I_EXEC); seq.push_back(ST_I_WB); end
      CL_LW, CL_SW: begin
        seq.push_back(ST_ADDR);
        mrq.push_back(1'($urandom % 2));
        for (int i = 0; i < mw; i++) begin
          seq.push_back(cl == CL_LW ? ST_LD_MEM : ST_ST_MEM); mrq.push_back(1'b0);
        end
        seq.push_back(cl == CL_LW ? ST_LD_MEM : ST_ST_MEM); mrq.push_back(1'b1);
        if (cl == CL_LW) seq.push_back(ST_LD_WB);
      end
      CL_BR:  seq.push_back(ST_BRANCH);
      CL_J:   seq.push_back(ST_JUMP);
      CL_JAL: seq.push_back(ST_JAL);
      CL_JR:  seq.push_back(ST_JR);
      default: seq.push_back(ST_HALT);
    endcase
    while (mrq.size() < seq.size()) mrq.push_back(1'($urandom % 2));

    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      op_in = op; fn_in = fn; mem_ready = mrq[i];
      #1;
      if (i == abort_at) begin
        reset = 1'b1;
        #1 check_cleared("abort");
        model_cnt = 0;
        return;
      end
      if (seq[i] == ST_HALT && cl == CL_SYS) model_cnt++;
      check($sformatf("state op%0d fn%0d c%0d", op, fn, i), 32'(state_out), seq[i]);
      check($sformatf("ctrl op%0d fn%0d c%0d", op, fn, i), 32'(ctrl_out),
            32'(exp_ctrl(seq[i], op, mrq[i])));
      check($sformatf("count op%0d c%0d", op, i), instr_count, model_cnt);
      check($sformatf("halted op%0d c%0d", op, i), 32'(halted), 32'(seq[i] == ST_HALT));
      check($sformatf("illegal op%0d c%0d", op, i), 32'(illegal),
            32'(seq[i] == ST_HALT && cl == CL_ILL));
    end

    if (cl == CL_SYS || cl == CL_ILL) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        op_in = 6'($urandom); fn_in = 6'($urandom); mem_ready = 1'($urandom % 2);
        #1;
        check("halt.state", 32'(state_out), ST_HALT);
        check("halt.ctrl", 32'(ctrl_out), 32'd0);
        check("halt.halted", 32'(halted), 32'd1);
        check("halt.illegal", 32'(illegal), 32'(cl == CL_ILL));
        check("halt.count", instr_count, model_cnt);
      end
    end else begin
      model_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; op_in = '0; fn_in = '0; mem_ready = 1'b1;
    do_reset();

    // Basic R-type, load with memory stall, fetch stall
    run_instr(6'd0, 6'd32, 0, 0, -1);
    run_instr(6'd35, 6'd0, 0, 3, -1);
    run_instr(6'd0, 6'd34, 5, 0, -1);

    // Branches, jumps, store, immediates
    run_instr(6'd4, 6'd0, 0, 0, -1);
    run_instr(6'd5, 6'd0, 1, 0, -1);
    run_instr(6'd3, 6'd0, 0, 0, -1);
    run_instr(6'd2, 6'd0, 0, 0, -1);
    run_instr(6'd0, 6'd8, 0, 0, -1);
    run_instr(6'd43, 6'd0, 2, 2, -1);
    run_instr(6'd15, 6'd0, 0, 0, -1);

    // Random stream of legal instructions
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = legal_ops[$urandom_range(0, 12)];
      fn = 6'($urandom_range(0, 63));
      if (op == 6'd0 && fn == 6'd12) fn = 6'd32;
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    // Illegal opcode halts and flags
    run_instr(6'd63, 6'd0, 0, 0, -1);
    do_reset();

    // Syscall halts, counted, not illegal
    run_instr(6'd8, 6'd0, 0, 0, -1);
    run_instr(6'd0, 6'd12, 1, 0, -1);
    do_reset();

    // Reset during a load's memory wait
    run_instr(6'd0, 6'd36, 0, 0, -1);
    run_instr(6'd35, 6'd0, 0, 6, 5);
    do_reset();
    run_instr(6'd13, 6'd0, 0, 0, -1);
    run_instr(6'd0, 6'd37, 0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
